// File: rtl/addsub_pkg.sv
// Shared types and defaults for the sequential slice-by-slice adder/subtractor.
// Optional feature macro: ADDSUB_SAT_EN (saturating result on signed overflow).
package addsub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  // Controller states; the encoding is visible on the top-level debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slice_add.sv
// Combinational SLICE-bit adder with carry in/out. Also reports the carry
// into the slice MSB so the caller can derive signed overflow on the top slice.
module slice_add #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE:0] full;

  // Plain widened addition; the MSB carry-in is recovered from the MSB sum bit.
  always_comb begin
    full    = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    sum     = full[SLICE-1:0];
    cout    = full[SLICE];
    msb_cin = a[SLICE-1] ^ b[SLICE-1] ^ full[SLICE-1];
  end

endmodule

// File: rtl/addsub16_seq.sv
// Sequential add/subtract: operands are captured once, then summed SLICE bits
// per cycle, LSB slice first. Result is held until the consumer takes it.
// Optional feature macro: ADDSUB_SAT_EN -- saturate y on signed overflow.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; y/cout/ovf
// are stable for as long as out_valid is high, and the cycle that retires a
// result never also accepts new operands.
module addsub16_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [WIDTH-1:0] a,
  input  logic        [WIDTH-1:0] b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    cout,
  output logic                    ovf,
  output logic        [1:0]       dbg_state
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [CW-1:0]     count;

  logic [SLICE-1:0]  sa;
  logic [SLICE-1:0]  sb;
  logic [SLICE-1:0]  s_sum;
  logic              s_cout;
  logic              s_msb;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  // Pick the operand slice addressed by the running slice count.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (count == CW'(i)) begin
        sa = a_r[i*SLICE +: SLICE];
        sb = b_r[i*SLICE +: SLICE];
      end
    end
  end

  slice_add #(.SLICE(SLICE)) u_slice (
    .a       (sa),
    .b       (sb),
    .cin     (carry),
    .sum     (s_sum),
    .cout    (s_cout),
    .msb_cin (s_msb)
  );

  // Controller and datapath registers; subtraction is a + ~b + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      count <= '0;
      y     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < NSL; i++) begin
            if (count == CW'(i)) y[i*SLICE +: SLICE] <= s_sum;
          end
          carry <= s_cout;
          count <= count + CW'(1);
          if (count == LAST) begin
            cout  <= s_cout;
            ovf   <= s_msb ^ s_cout;
`ifdef ADDSUB_SAT_EN
            // Overflow only happens when the result sign is wrong, so clamp
            // toward the sign of a.
            if (s_msb ^ s_cout) begin
              y <= a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
